// File: rtl/if_prefetch_queue_pkg.sv
// Shared constants for the instruction-fetch prefetch queue.
package if_prefetch_queue_pkg;

    localparam logic [31:0] RV32_NOP = 32'h0000_0013;
    localparam int unsigned PC_INC   = 4;

endpackage

// File: rtl/if_prefetch_queue_sync_fifo.sv
// Synchronous FIFO with flush and occupancy count; simultaneous push/pop allowed when full.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != CW'(DEPTH)) || w_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push && !i_flush) r_mem[r_wptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue: credit-limited fetch requests, in-order PC tagging,
// registered instruction queue toward decode, and redirect flush with response dropping.
module if_prefetch_queue
    import if_prefetch_queue_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_pc_redirect,
    input  logic [XLEN-1:0]           i_pc_redirect_target,
    output logic                      o_imem_req,
    output logic [XLEN-1:0]           o_imem_raddr,
    input  logic                      i_imem_ready,
    input  logic                      i_imem_valid,
    input  logic [XLEN-1:0]           i_imem_rdata,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [XLEN-1:0]           o_inst,
    output logic [XLEN-1:0]           o_fetch_pc,
    output logic [XLEN-1:0]           o_pc_plus_4,
    output logic [$clog2(DEPTH):0]    o_occupancy
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = CW + 1;

    logic [XLEN-1:0]   r_pc;
    logic [CW-1:0]     r_drop;
    logic [CW-1:0]     w_tag_count;
    logic [CW-1:0]     w_occupancy;
    logic [CW-1:0]     w_outstanding;
    logic [CW-1:0]     w_drop_reload;
    logic [XLEN-1:0]   w_tag_pc;
    logic [2*XLEN-1:0] w_head;
    logic              w_accept;
    logic              w_resp_keep;
    logic              w_pop;

    // Tagged requests plus still-to-drop responses are exactly the in-flight requests.
    assign w_outstanding = w_tag_count + r_drop;
    assign w_drop_reload = w_outstanding - CW'(i_imem_valid);

    assign o_imem_req  = !i_rst && !i_pc_redirect && (r_drop == '0) &&
                         ((SW'(w_outstanding) + SW'(w_occupancy)) < SW'(DEPTH));
    assign w_accept    = o_imem_req && i_imem_ready;
    assign w_resp_keep = i_imem_valid && (r_drop == '0) && !i_pc_redirect;
    assign w_pop       = o_valid && i_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc   <= RESET_ADDR;
            r_drop <= '0;
        end else if (i_pc_redirect) begin
            r_pc   <= i_pc_redirect_target;
            r_drop <= w_drop_reload;
        end else begin
            if (w_accept) r_pc <= r_pc + XLEN'(PC_INC);
            if (i_imem_valid && (r_drop != '0)) r_drop <= r_drop - CW'(1);
        end
    end

    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (i_pc_redirect),
        .i_push  (w_accept),
        .i_wdata (r_pc),
        .i_pop   (w_resp_keep),
        .o_rdata (w_tag_pc),
        .o_count (w_tag_count)
    );

    sync_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (DEPTH)
    ) u_inst_queue (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (i_pc_redirect),
        .i_push  (w_resp_keep),
        .i_wdata ({w_tag_pc, i_imem_rdata}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_count (w_occupancy)
    );

    assign o_imem_raddr = r_pc;
    assign o_valid      = (w_occupancy != '0);
    assign o_occupancy  = w_occupancy;
    assign o_fetch_pc   = w_head[2*XLEN-1:XLEN];
    assign o_inst       = o_valid ? w_head[XLEN-1:0] : XLEN'(RV32_NOP);
    assign o_pc_plus_4  = o_fetch_pc + XLEN'(PC_INC);

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Randomised and directed bench for if_prefetch_queue against an epoch-based queue model.
module tb_if_prefetch_queue;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RESET_ADDR = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_pc_redirect = 1'b0;
    logic [31:0] i_pc_redirect_target = '0;
    logic        o_imem_req;
    logic [31:0] o_imem_raddr;
    logic        i_imem_ready = 1'b0;
    logic        i_imem_valid = 1'b0;
    logic [31:0] i_imem_rdata = '0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_inst;
    logic [31:0] o_fetch_pc;
    logic [31:0] o_pc_plus_4;
    logic [2:0]  o_occupancy;

    always #5 clk = ~clk;

    if_prefetch_queue #(
        .XLEN       (XLEN),
        .RESET_ADDR (RESET_ADDR),
        .DEPTH      (DEPTH)
    ) u_dut (
        .i_clk                (clk),
        .i_rst                (rst),
        .i_pc_redirect        (i_pc_redirect),
        .i_pc_redirect_target (i_pc_redirect_target),
        .o_imem_req           (o_imem_req),
        .o_imem_raddr         (o_imem_raddr),
        .i_imem_ready         (i_imem_ready),
        .i_imem_valid         (i_imem_valid),
        .i_imem_rdata         (i_imem_rdata),
        .o_valid              (o_valid),
        .i_ready              (i_ready),
        .o_inst               (o_inst),
        .o_fetch_pc           (o_fetch_pc),
        .o_pc_plus_4          (o_pc_plus_4),
        .o_occupancy          (o_occupancy)
    );

    typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

    req_t        inflight[$];
    ent_t        q[$];
    logic [31:0] acc_q[$];
    logic [31:0] m_pc = RESET_ADDR;
    int          epoch = 0;
    int          cyc = 0;
    int          last_due = 0;
    int          max_lat = 0;
    int          errors = 0;
    int          checks = 0;
    int          cnt_pc0 = 0;

    logic        s_req, s_valid;
    logic [31:0] s_raddr, s_pc;
    logic [2:0]  s_occ;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at a negedge: drive, compare against the model, advance the model, wait one cycle.
    task automatic step(input logic redir, input logic [31:0] tgt, input logic mready,
                        input logic iready, input logic resp_en);
        logic exp_req, resp, pop, stale;
        req_t h;
        req_t r;
        ent_t e;
        resp = resp_en && (inflight.size() > 0) && (inflight[0].due <= cyc);
        i_pc_redirect        = redir;
        i_pc_redirect_target = tgt;
        i_imem_ready         = mready;
        i_ready              = iready;
        i_imem_valid         = resp;
        i_imem_rdata         = resp ? memfn(inflight[0].addr) : $urandom;
        #1;
        s_req = o_imem_req; s_raddr = o_imem_raddr; s_valid = o_valid;
        s_pc = o_fetch_pc; s_occ = o_occupancy;
        if (o_imem_req && mready) acc_q.push_back(o_imem_raddr);
        if (o_valid && iready && !redir && o_fetch_pc == 32'h0) cnt_pc0++;

        stale = 1'b0;
        foreach (inflight[i]) if (inflight[i].epoch != epoch) stale = 1'b1;
        exp_req = !redir && !stale && ((inflight.size() + q.size()) < DEPTH);
        chk("imem_req", 32'(o_imem_req), 32'(exp_req));
        if (exp_req) chk("imem_raddr", o_imem_raddr, m_pc);
        chk("valid", 32'(o_valid), 32'(q.size() > 0));
        chk("occupancy", 32'(o_occupancy), 32'(q.size()));
        if (q.size() > 0) begin
            chk("fetch_pc", o_fetch_pc, q[0].pc);
            chk("inst", o_inst, q[0].inst);
            chk("pc_plus_4", o_pc_plus_4, q[0].pc + 32'd4);
        end

        pop = (q.size() > 0) && iready && !redir;
        if (pop) void'(q.pop_front());
        if (resp) begin
            h = inflight.pop_front();
            if (h.epoch == epoch && !redir) begin
                e.pc = h.addr; e.inst = memfn(h.addr);
                q.push_back(e);
            end
        end
        if (redir) begin
            q.delete();
            epoch++;
            m_pc = tgt;
        end else if (exp_req && mready) begin
            r.addr = m_pc; r.epoch = epoch;
            r.due = cyc + 1 + $urandom_range(0, max_lat);
            if (r.due < last_due) r.due = last_due;
            last_due = r.due;
            inflight.push_back(r);
            m_pc = m_pc + 32'd4;
        end
        cyc++;
        @(negedge clk);
    endtask

    // Called at a negedge; reset outputs must fall without any clock edge.
    task automatic do_reset();
        rst = 1'b1;
        i_pc_redirect = 1'b0; i_imem_ready = 1'b0; i_imem_valid = 1'b0; i_ready = 1'b0;
        #1;
        chk("rst_valid", 32'(o_valid), 32'h0);
        chk("rst_req", 32'(o_imem_req), 32'h0);
        chk("rst_occupancy", 32'(o_occupancy), 32'h0);
        inflight.delete();
        q.delete();
        m_pc = RESET_ADDR;
        last_due = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic seen_req, seen_valid;
        @(negedge clk);

        // Zero-wait streaming from reset.
        max_lat = 0;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            step(1'b0, '0, 1'b1, 1'b1, 1'b1);
            if (k == 0) begin chk("first_req", 32'(s_req), 32'h1); chk("first_addr", s_raddr, 32'h0); end
            if (k == 1) chk("valid_lat_k1", 32'(s_valid), 32'h0);
            if (k == 2) begin chk("valid_lat_k2", 32'(s_valid), 32'h1); chk("pc_k2", s_pc, 32'h0); end
            if (k == 3) chk("pc_k3", s_pc, 32'h4);
            if (k == 4) chk("pc_k4", s_pc, 32'h8);
        end

        // Decode stall fills the queue and stops requests.
        for (int k = 0; k < 10; k++) step(1'b0, '0, 1'b1, 1'b0, 1'b1);
        chk("stall_occupancy", 32'(s_occ), 32'h4);
        chk("stall_req", 32'(s_req), 32'h0);
        for (int k = 0; k < 10; k++) step(1'b0, '0, 1'b1, 1'b1, 1'b1);

        // Redirect with three requests in flight.
        do_reset();
        for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h100, 1'b1, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1, 1'b1);
        chk("drop_no_req", 32'(s_req), 32'h0);
        seen_req = 1'b0; seen_valid = 1'b0;
        for (int k = 0; k < 20 && !seen_valid; k++) begin
            step(1'b0, '0, 1'b1, 1'b1, 1'b1);
            if (s_req && !seen_req) begin seen_req = 1'b1; chk("redir_req_addr", s_raddr, 32'h100); end
            if (s_valid && !seen_valid) begin seen_valid = 1'b1; chk("redir_first_pc", s_pc, 32'h100); end
        end
        chk("redir_delivered", 32'(seen_valid), 32'h1);

        // Redirect together with a response and a pop.
        do_reset();
        for (int k = 0; k < 4; k++) step(1'b0, '0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 32'h200, 1'b1, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1, 1'b1);
        chk("flush_valid", 32'(s_valid), 32'h0);
        seen_valid = 1'b0;
        for (int k = 0; k < 20 && !seen_valid; k++) begin
            step(1'b0, '0, 1'b1, 1'b1, 1'b1);
            if (s_valid) begin seen_valid = 1'b1; chk("flush_first_pc", s_pc, 32'h200); end
        end
        chk("flush_delivered", 32'(seen_valid), 32'h1);

        // Memory backpressure holds the request.
        do_reset();
        cnt_pc0 = 0;
        for (int k = 0; k < 5; k++) begin
            step(1'b0, '0, 1'b0, 1'b1, 1'b1);
            chk("hold_req", 32'(s_req), 32'h1);
            chk("hold_addr", s_raddr, 32'h0);
        end
        for (int k = 0; k < 8; k++) step(1'b0, '0, 1'b1, 1'b1, 1'b1);
        chk("pc0_once", 32'(cnt_pc0), 32'h1);

        // Address wrap, then reset mid-burst.
        step(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1, 1'b1);
        acc_q.delete();
        for (int k = 0; k < 6; k++) step(1'b0, '0, 1'b1, 1'b1, 1'b1);
        if (acc_q.size() >= 3) begin
            chk("wrap_a0", acc_q[0], 32'hFFFF_FFF8);
            chk("wrap_a1", acc_q[1], 32'hFFFF_FFFC);
            chk("wrap_a2", acc_q[2], 32'h0000_0000);
        end else begin
            chk("wrap_accepts", 32'(acc_q.size()), 32'd3);
        end
        do_reset();

        // Random traffic.
        for (int n = 0; n < 4000; n++) begin
            if (n % 128 == 0) max_lat = $urandom_range(0, 3);
            if ($urandom_range(0, 999) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 99) < 3,
                     ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                                 : ($urandom & 32'hFFFF_FFFC),
                     $urandom_range(0, 99) < 70,
                     $urandom_range(0, 99) < 60,
                     $urandom_range(0, 99) < 75);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_prefetch_queue.md
IF_PREFETCH_QUEUE -- requirements
Module: if_prefetch_queue

Interface
REQ-001 SHALL have parameter RESET_ADDR, default 32'h00000000: PC loaded at reset.
REQ-002 SHALL have parameter DEPTH, default 4: queue entries and outstanding-request limit; power of 2, minimum 2.
REQ-003 SHALL have parameter XLEN, default 32: address and instruction width.
REQ-004 SHALL have port i_clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port i_rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port i_pc_redirect, input, 1: flush and restart fetch at the target.
REQ-007 SHALL have port i_pc_redirect_target, input, XLEN: new fetch address.
REQ-008 SHALL have port o_imem_req, output, 1: request valid.
REQ-009 SHALL have port o_imem_raddr, output, XLEN: request address.
REQ-010 SHALL have port i_imem_ready, input, 1: request accepted when high together with o_imem_req.
REQ-011 SHALL have port i_imem_valid, input, 1: response valid; responses arrive in order, at least 1 cycle after acceptance.
REQ-012 SHALL have port i_imem_rdata, input, XLEN: response instruction.
REQ-013 SHALL have port o_valid, input-to-ID handshake output, 1: queue head valid.
REQ-014 SHALL have port i_ready, input, 1: ID consumes the head (deasserted on hazard stall).
REQ-015 SHALL have port o_inst, output, XLEN: head instruction.
REQ-016 SHALL have port o_fetch_pc, output, XLEN: head PC.
REQ-017 SHALL have port o_pc_plus_4, output, XLEN: o_fetch_pc + 4.
REQ-018 SHALL have port o_occupancy, output, clog2(DEPTH)+1: number of valid entries.

Function
REQ-019 Fetch PC SHALL advance by 4 (modulo 2^XLEN) on every accepted request (o_imem_req && i_imem_ready).
REQ-020 o_imem_req SHALL be high iff not in reset, i_pc_redirect is low, and outstanding + occupancy < DEPTH (credit rule guarantees that every response has a free slot).
REQ-021 o_imem_raddr SHALL equal the fetch PC; address and o_imem_req SHALL hold stable while o_imem_req && !i_imem_ready.
REQ-022 Each accepted request SHALL push its address into an in-order PC tag FIFO of DEPTH entries; each non-dropped response SHALL pair its data with the oldest tag and be written to the queue tail.
REQ-023 Outstanding count SHALL be incremented on acceptance and decremented on response; simultaneous events SHALL leave it unchanged.
REQ-024 Head SHALL pop when o_valid && i_ready; push and pop SHALL be allowed in the same cycle, including when the queue is full or holds one entry.
REQ-025 Response-to-o_valid latency SHALL be 1 cycle (registered queue; no bypass).
REQ-026 On i_pc_redirect, the next edge SHALL: empty the queue, set fetch PC = target, load drop counter = outstanding count after this cycle's updates, and clear the tag FIFO.
REQ-027 While drop counter > 0, each i_imem_valid SHALL be discarded and decrement it; no new request SHALL issue until it reaches 0.
REQ-028 Redirect coinciding with a response or pop SHALL flush: that response is dropped and o_valid is 0 the following cycle.
REQ-029 A redirect arriving during a drop phase SHALL reload the drop counter per REQ-026 and take the newest target.
REQ-030 Pointers SHALL wrap modulo DEPTH; o_occupancy SHALL distinguish full (DEPTH) from empty (0).

Reset
REQ-031 On i_rst: fetch PC = RESET_ADDR; queue, tag FIFO, outstanding and drop counters = 0; o_valid = 0, o_imem_req = 0, o_occupancy = 0; o_inst, o_fetch_pc and o_pc_plus_4 are don't-care while o_valid = 0.
REQ-032 Reset mid-transaction SHALL abandon in-flight requests; the memory model is reset by the same i_rst.

Structure
REQ-033 The shared package SHALL hold the RV32 NOP constant (32'h00000013) and the PC increment constant (4).
REQ-034 One sub-module, sync_fifo (parametrised width/depth, occupancy count), SHALL be instantiated twice: instruction queue and PC tag FIFO.

Verification
REQ-035 Reset, 0-cycle-wait memory, i_ready=1 -> first request at 0x0; o_valid 2 cycles after reset release; PCs 0,4,8,... with one instruction per cycle.
REQ-036 i_ready=0 for 10 cycles, DEPTH=4 -> o_occupancy=4, o_imem_req=0; after i_ready=1, the sequence continues without loss or duplication.
REQ-037 3 requests outstanding, redirect to 0x100 -> 3 responses dropped, next request 0x100, first delivered o_fetch_pc=0x100.
REQ-038 Redirect in the same cycle as a response and a pop -> o_valid=0 next cycle, no stale instruction is delivered.
REQ-039 i_imem_ready held low 5 cycles -> o_imem_raddr stable and the request is issued exactly once.
REQ-040 PC=0xFFFFFFFC fetch -> next request address 0x00000000; i_rst asserted mid-burst -> all outputs reach reset values asynchronously.
